// File: rtl/fetch_ctrl_if.sv
// IF-stage sequencer bus: PC/hazard/redirect inputs and NPC/status outputs.
interface fetch_ctrl_if;
   localparam int unsigned XLEN = 32;

   logic [XLEN-1:0] pc;
   logic            stall;
   logic            br_taken;
   logic [XLEN-1:0] br_target;
   logic            exc_req;
   logic            halt_req;
   logic            resume;
   logic [XLEN-1:0] npc;
   logic            pc_en;
   logic [1:0]      state;
   logic            fault;
   logic [XLEN-1:0] fault_addr;
   logic [XLEN-1:0] fetch_cnt;

   // environment side: drives PC and control requests, observes sequencer
   modport master (
      output pc, stall, br_taken, br_target, exc_req, halt_req, resume,
      input  npc, pc_en, state, fault, fault_addr, fetch_cnt
   );

   // sequencer side
   modport slave (
      input  pc, stall, br_taken, br_target, exc_req, halt_req, resume,
      output npc, pc_en, state, fault, fault_addr, fetch_cnt
   );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: picks next PC, gates PC load, holds stalled redirects,
// supports halt/resume and traps fetches outside the instruction ROM window.
module fetch_ctrl #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter int unsigned ROM_WORDS  = 4096,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
   input logic           clk,
   input logic           reset,
   fetch_ctrl_if.slave   bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned AW   = XLEN + 1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_HOLD  = 2'd1,
      ST_HALT  = 2'd2,
      ST_FAULT = 2'd3
   } state_t;

   // window bounds widened by one bit so the top bound cannot wrap
   localparam logic [AW-1:0] WIN_LO = {1'b0, RESET_PC};
   localparam logic [AW-1:0] WIN_HI = WIN_LO + (AW'(ROM_WORDS) << 2);

   state_t            state_q;
   logic [XLEN-1:0]   pend_tgt;
   logic              fault_q;
   logic [XLEN-1:0]   fault_addr_q;
   logic [XLEN-1:0]   fetch_cnt_q;

   logic [XLEN-1:0]   seq_pc;
   logic [XLEN-1:0]   cand;
   logic              want_en;
   logic              illegal;

   assign seq_pc = bus.pc + XLEN'(4);

   // candidate next PC and whether this cycle would load it
   always_comb begin
      cand    = seq_pc;
      want_en = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bus.exc_req) begin
               cand    = EXC_VECTOR;
               want_en = 1'b1;
            end else if (bus.br_taken) begin
               cand    = bus.br_target;
               want_en = !bus.stall;
            end else begin
               want_en = !bus.stall && !bus.halt_req;
            end
         end
         ST_HOLD: begin
            if (bus.exc_req) begin
               cand    = EXC_VECTOR;
               want_en = 1'b1;
            end else begin
               cand    = pend_tgt;
               want_en = !bus.stall;
            end
         end
         ST_HALT: begin
            if (bus.exc_req) begin
               cand    = EXC_VECTOR;
               want_en = 1'b1;
            end else begin
               want_en = bus.resume && !bus.stall;
            end
         end
         default: begin
            cand    = seq_pc;
            want_en = 1'b0;
         end
      endcase
   end

   // a load that would leave the ROM window or be misaligned is trapped
   always_comb begin
      illegal = want_en &&
                ((cand[1:0] != 2'b00) ||
                 ({1'b0, cand} <  WIN_LO) ||
                 ({1'b0, cand} >= WIN_HI));
   end

   assign bus.npc        = cand;
   assign bus.pc_en      = reset && want_en && !illegal;
   assign bus.state      = 2'(state_q);
   assign bus.fault      = fault_q;
   assign bus.fault_addr = fault_addr_q;
   assign bus.fetch_cnt  = fetch_cnt_q;

   // state, pending redirect, fault capture and fetch counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_RUN;
         pend_tgt     <= '0;
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         fetch_cnt_q  <= '0;
      end else begin
         if (bus.pc_en) begin
            fetch_cnt_q <= fetch_cnt_q + XLEN'(1);
         end
         if (illegal) begin
            fault_q      <= 1'b1;
            fault_addr_q <= cand;
            state_q      <= ST_FAULT;
         end else begin
            case (state_q)
               ST_RUN: begin
                  if (!bus.exc_req) begin
                     if (bus.br_taken && bus.stall) begin
                        pend_tgt <= bus.br_target;
                        state_q  <= ST_HOLD;
                     end else if (!bus.br_taken && bus.halt_req && !bus.stall) begin
                        state_q  <= ST_HALT;
                     end
                  end
               end
               ST_HOLD: begin
                  if (bus.exc_req || !bus.stall) begin
                     state_q <= ST_RUN;
                  end
               end
               ST_HALT: begin
                  if (bus.exc_req || bus.resume) begin
                     state_q <= ST_RUN;
                  end
               end
               default: begin
                  state_q <= ST_FAULT;
               end
            endcase
         end
      end
   end
endmodule
